// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared types and helpers for the pipelined add/subtract unit
//
// Purpose: operation encodings, chunk-width helper and the per-stage
// control record carried alongside the partial sum.
// Ports: none (package).
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  // Control travelling down the pipe with each beat; the operand MSBs are
  // captured up front so the signed-overflow rule can be applied at the
  // last stage without keeping the full operands alive that far.
  typedef struct packed {
    logic signed_en;
    op_e  op;
    logic a_msb;
    logic b_msb;
  } stage_ctrl_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CW-bit add slice with carry and zero detect
//
// Purpose: one carry-chain segment; the top instantiates one per stage.
// Ports:
//   a, b  in  CW  operand chunks (b already inverted for subtract ops)
//   cin   in  1   carry from the previous chunk
//   sum   out CW  chunk sum
//   cout  out 1   carry out of this chunk
//   zero  out 1   sum == 0
module addsub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          zero
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
  assign zero        = (sum == '0);

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - pipelined add/subtract unit with NZCV-style flags and sticky overflow
//
// Purpose: splits the WIDTH-bit carry chain into STAGES chunks, one register
// stage per chunk, behind a valid/ready stream interface with stall support.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          operand beat handshake
//   a, b, op, cin, signed_en   operands, operation, carry in, flag mode
//   out_valid/out_ready        result beat handshake
//   result, cout               sum/difference and carry out of MSB
//   zero_flag, negative_flag   result == 0, sign (signed mode only)
//   overflow_flag              signed V or unsigned carry/borrow
//   ovf_clr/ovf_sticky         clear / sticky overflow seen on a delivered beat
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic             signed_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero_flag,
  output logic             negative_flag,
  output logic             overflow_flag,
  input  logic             ovf_clr,
  output logic             ovf_sticky
);

  localparam int CW   = chunk_width(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  // Stage registers
  logic [STAGES-1:0]             v_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, sum_q;
  logic [STAGES-1:0]             carry_q, zero_q;
  stage_ctrl_t [STAGES-1:0]      ctrl_q;
  logic                          ovf_sticky_q;

  // Per-stage inputs (stage 0 from the ports, stage k from stage k-1)
  logic [STAGES-1:0][WIDTH-1:0]  a_src, b_src, sum_src;
  logic [STAGES-1:0]             carry_src, zero_src;
  stage_ctrl_t [STAGES-1:0]      ctrl_src;
  logic [WIDTH-1:0]              b_eff;
  logic                          cin_eff;

  // Chunk adder I/O
  logic [STAGES-1:0][CW-1:0]     ch_a, ch_b, ch_sum;
  logic [STAGES-1:0]             ch_cout, ch_zero;

  // Next-state and handshake
  logic [STAGES-1:0][WIDTH-1:0]  sum_d;
  logic [STAGES-1:0]             zero_d, v_d, adv, load;
  logic                          room;
  logic                          signed_v, ovf_sticky_d;

  assign b_eff = op[0] ? ~b : b;

  always_comb begin
    cin_eff = cin;
    case (op_e'(op))
      OP_ADD:  cin_eff = 1'b0;
      OP_SUB:  cin_eff = 1'b1;
      default: cin_eff = cin;
    endcase
  end

  always_comb begin
    a_src            = '0;
    b_src            = '0;
    sum_src          = '0;
    carry_src        = '0;
    zero_src         = '0;
    ctrl_src         = '0;
    ch_a             = '0;
    ch_b             = '0;
    a_src[0]         = a;
    b_src[0]         = b_eff;
    carry_src[0]     = cin_eff;
    zero_src[0]      = 1'b1;
    ctrl_src[0]      = '{signed_en: signed_en, op: op_e'(op),
                         a_msb: a[WIDTH-1], b_msb: b_eff[WIDTH-1]};
    for (int k = 1; k < STAGES; k++) begin
      a_src[k]     = a_q[k-1];
      b_src[k]     = b_q[k-1];
      sum_src[k]   = sum_q[k-1];
      carry_src[k] = carry_q[k-1];
      zero_src[k]  = zero_q[k-1];
      ctrl_src[k]  = ctrl_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ch_a[k] = a_src[k][k*CW +: CW];
      ch_b[k] = b_src[k][k*CW +: CW];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk #(.CW(CW)) u_chunk (
      .a    (ch_a[k]),
      .b    (ch_b[k]),
      .cin  (carry_src[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k]),
      .zero (ch_zero[k])
    );
  end

  // Each stage fills in its own chunk of the running sum and ANDs its
  // chunk-zero into the running zero flag.
  always_comb begin
    sum_d  = sum_src;
    zero_d = zero_src & ch_zero;
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k][k*CW +: CW] = ch_sum[k];
    end
  end

  // Stall chain walked from the output back to the input. 'room' means the
  // stage downstream of k can take a beat this cycle; it ends up as in_ready,
  // so in_ready follows out_ready combinationally.
  always_comb begin
    adv  = '0;
    load = '0;
    v_d  = v_q;
    room = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k] = v_q[k] && room;
      room   = !v_q[k] || adv[k];
    end
    in_ready = room;
    load[0]  = in_valid && room;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (load[k]) begin
        v_d[k] = 1'b1;
      end else if (adv[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= '0;
      zero_q       <= '0;
      ctrl_q       <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      v_q <= v_d;
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          a_q[k]     <= a_src[k];
          b_q[k]     <= b_src[k];
          sum_q[k]   <= sum_d[k];
          carry_q[k] <= ch_cout[k];
          zero_q[k]  <= zero_d[k];
          ctrl_q[k]  <= ctrl_src[k];
        end
      end
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign out_valid     = v_q[LAST];
  assign result        = sum_q[LAST];
  assign cout          = carry_q[LAST];
  assign zero_flag     = zero_q[LAST];
  assign negative_flag = ctrl_q[LAST].signed_en & result[WIDTH-1];

  assign signed_v = (ctrl_q[LAST].a_msb == ctrl_q[LAST].b_msb) &&
                    (result[WIDTH-1] != ctrl_q[LAST].a_msb);

  // Unsigned: carry out means overflow for adds, missing carry means borrow for subtracts.
  assign overflow_flag = ctrl_q[LAST].signed_en ? signed_v
                                                : (ctrl_q[LAST].op[0] ? ~cout : cout);

  // Setting wins over a simultaneous clear so a delivered overflow is never missed.
  assign ovf_sticky_d = (out_valid && out_ready && overflow_flag) ? 1'b1 :
                        ovf_clr ? 1'b0 : ovf_sticky_q;
  assign ovf_sticky   = ovf_sticky_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - self-checking bench for addsub_pipe (WIDTH=32, STAGES=4)
module tb_addsub_pipe;

  localparam int W = 32;
  localparam int S = 4;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         cin = 1'b0;
  logic         signed_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         cout, zero_flag, negative_flag, overflow_flag;
  logic         ovf_clr = 1'b0;
  logic         ovf_sticky;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t  sb[$];
  exp_t  mon_e;
  int    n_assert = 0;
  int    n_fail = 0;
  int    n_deliv = 0;
  int    run = 0;
  int    max_run = 0;
  int    base, lat;
  logic  rand_rdy = 1'b0;
  logic  stall_prev = 1'b0;
  logic [35:0] held = '0;

  addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .op            (op),
    .cin           (cin),
    .signed_en     (signed_en),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .result        (result),
    .cout          (cout),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag),
    .overflow_flag (overflow_flag),
    .ovf_clr       (ovf_clr),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [1:0] mop, input logic mc, input logic ms);
    logic [32:0] w;
    longint      sa, sb_, sr;
    exp_t        e;
    sa  = longint'($signed(ma));
    sb_ = longint'($signed(mb));
    case (mop)
      2'b00: begin w = {1'b0, ma} + {1'b0, mb};                sr = sa + sb_; end
      2'b01: begin w = {1'b0, ma} - {1'b0, mb};                sr = sa - sb_; end
      2'b10: begin w = {1'b0, ma} + {1'b0, mb} + {32'd0, mc};  sr = sa + sb_ + longint'(mc); end
      default: begin w = {1'b0, ma} - {1'b0, mb} - {32'd0, !mc}; sr = sa - sb_ - 1 + longint'(mc); end
    endcase
    e.res = w[31:0];
    e.c   = mop[0] ? ~w[32] : w[32];
    e.z   = (e.res == 32'd0);
    e.n   = ms & e.res[31];
    e.v   = ms ? ((sr > MAXS) || (sr < MINS)) : (mop[0] ? ~e.c : e.c);
    return e;
  endfunction

  task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic [1:0] top,
                      input logic tcin, input logic tse);
    int t = 0;
    a = ta; b = tb_v; op = top; cin = tcin; signed_en = tse; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    sb.push_back(model(ta, tb_v, top, tcin, tse));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("out_valid_seen", 64'(out_valid), 64'd1);
  endtask

  task automatic drain(input int limit);
    int t = 0;
    while (sb.size() != 0 && t < limit) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Random output back-pressure while enabled.
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: scoreboard pop on every delivered beat, hold check on stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      run = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'({result, cout, zero_flag, negative_flag, overflow_flag}), 64'(held));
      end
      if (out_valid) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(sb.size()), 64'd1);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_result", 64'(result), 64'(mon_e.res));
          chk("sb_cout", 64'(cout), 64'(mon_e.c));
          chk("sb_zero", 64'(zero_flag), 64'(mon_e.z));
          chk("sb_neg", 64'(negative_flag), 64'(mon_e.n));
          chk("sb_ovf", 64'(overflow_flag), 64'(mon_e.v));
        end
        n_deliv++;
      end
      stall_prev = out_valid && !out_ready;
      held = {result, cout, zero_flag, negative_flag, overflow_flag};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, observed hang expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_zero", 64'(zero_flag), 64'd0);
    chk("rst_neg", 64'(negative_flag), 64'd0);
    chk("rst_ovf", 64'(overflow_flag), 64'd0);
    chk("rst_sticky", 64'(ovf_sticky), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned ADD wrap: latency and flags
    send(32'hFFFF_FFFF, 32'h1, 2'b00, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    chk("add_result", 64'(result), 64'd0);
    chk("add_cout", 64'(cout), 64'd1);
    chk("add_zero", 64'(zero_flag), 64'd1);
    chk("add_ovf", 64'(overflow_flag), 64'd1);
    @(posedge clk);
    #1;
    chk("add_sticky", 64'(ovf_sticky), 64'd1);

    // Signed SUB overflow
    send(32'h8000_0000, 32'h1, 2'b01, 1'b0, 1'b1);
    wait_out();
    chk("sub_result", 64'(result), 64'h7FFF_FFFF);
    chk("sub_cout", 64'(cout), 64'd1);
    chk("sub_neg", 64'(negative_flag), 64'd0);
    chk("sub_ovf", 64'(overflow_flag), 64'd1);
    @(posedge clk);
    #1;

    // SBC with borrow, then ADC with carry in
    send(32'd5, 32'd7, 2'b11, 1'b1, 1'b1);
    wait_out();
    chk("sbc_result", 64'(result), 64'hFFFF_FFFE);
    chk("sbc_cout", 64'(cout), 64'd0);
    chk("sbc_neg", 64'(negative_flag), 64'd1);
    chk("sbc_ovf", 64'(overflow_flag), 64'd0);
    @(posedge clk);
    #1;
    send(32'd3, 32'd4, 2'b10, 1'b1, 1'b1);
    wait_out();
    chk("adc_result", 64'(result), 64'd8);
    @(posedge clk);
    #1;

    // Clear sticky
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    chk("clr_sticky", 64'(ovf_sticky), 64'd0);

    // 16 back-to-back beats with out_ready held high
    max_run = 0;
    repeat (16) send($urandom, $urandom, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain(100);
    chk("b2b_run", 64'(max_run), 64'd16);

    // Random back-pressure: order and count preserved
    base = n_deliv;
    rand_rdy = 1'b1;
    repeat (40) send($urandom, $urandom, 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain(2000);
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    chk("rand_count", 64'(n_deliv - base), 64'd40);

    // Fill with out_ready low, then reset mid-stream
    send(32'hFFFF_FFFF, 32'h2, 2'b00, 1'b0, 1'b0);
    drain(100);
    chk("fill_pre_sticky", 64'(ovf_sticky), 64'd1);
    out_ready = 1'b0;
    repeat (4) send($urandom, $urandom, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sticky", 64'(ovf_sticky), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // ovf_clr coincident with an overflowing delivery: set wins
    out_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'h1, 2'b00, 1'b0, 1'b1);
    wait_out();
    chk("g_pre_sticky", 64'(ovf_sticky), 64'd0);
    ovf_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("g_set_wins", 64'(ovf_sticky), 64'd1);
    @(posedge clk);
    #1;
    chk("g_cleared", 64'(ovf_sticky), 64'd0);
    ovf_clr = 1'b0;
    chk("g_sb_empty", 64'(sb.size()), 64'd0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
